multiport_register_file: RTL and testbench
==========================================

// Module: multiport_register_file
// PURPOSE
//  Parametrised integer register file for the core: N combinational read ports and one write port.
//  Adds write-to-read bypass, a per-register pending scoreboard (reserve on issue, release on writeback),
//  and a sequential clear engine that zeroes the array one entry per cycle after reset.
//  Sits between decode (read/reserve) and writeback (write); dbg port replaces the fixed x31 tap.
// PARAMETERS
//  XLEN      32  data width in bits
//  DEPTH     32  number of registers; power of two, >= 2; AW = $clog2(DEPTH) (localparam)
//  NUM_READ  2   number of read ports, >= 1
//  ZERO_REG  1   1: register 0 hardwired to zero (writes/reserves to it ignored)
//  BYPASS    1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clock       in   1               rising-edge clock
//  reset       in   1               synchronous, active-low
//  rs_addr     in   NUM_READ*AW     read addresses; port i = bits [i*AW +: AW]
//  rs_data     out  NUM_READ*XLEN   read data; port i = bits [i*XLEN +: XLEN]
//  rs_ready    out  NUM_READ        1 = rs_data[i] valid (not pending, or bypass hit)
//  wr_en       in   1               write strobe
//  wr_addr     in   AW              write address
//  wr_data     in   XLEN            write data
//  res_en      in   1               reserve strobe (mark register pending)
//  res_addr    in   AW              register to reserve
//  dbg_addr    in   AW              debug read address
//  dbg_data    out  XLEN            raw array contents at dbg_addr (no bypass)
//  busy        out  1               1 = reset or clear in progress; all strobes ignored
//  any_pending out  1               OR of all pending bits
// BEHAVIOUR
//  States: CLEARING, READY. reset==0 at posedge -> state=CLEARING, clr_idx=0, all pending=0.
//  CLEARING (reset==1): each cycle mem[clr_idx]<=0, clr_idx++; after clr_idx==DEPTH-1 -> READY.
//   busy=1 for the reset cycles plus exactly DEPTH cycles after release; first READY cycle busy=0.
//  Reset low mid-clear: clear restarts at index 0; array contents are don't-care until clear finishes.
//  While busy: rs_data=0, rs_ready=0, dbg_data=0, any_pending=0; wr_en/res_en have no effect.
//  READY write: wr_en && !(ZERO_REG && wr_addr==0) -> mem[wr_addr]<=wr_data, pending[wr_addr]<=0.
//  READY reserve: res_en && !(ZERO_REG && res_addr==0) -> pending[res_addr]<=1.
//  Write + reserve to same addr in same cycle: data written AND pending ends 1 (reserve wins).
//  Reserve of an already-pending register: stays 1 (no count; single outstanding writer per reg).
//  Read port i (combinational, 0-cycle):
//   ZERO_REG && addr==0           -> data=0, ready=1
//   BYPASS && wr_en && wr_addr==addr (and legal write) -> data=wr_data, ready=1
//   otherwise                      -> data=mem[addr], ready=!pending[addr]
//   Reserve in cycle t does not affect reads in cycle t; rs_ready drops from cycle t+1.
//  BYPASS=0: reads see written data from cycle t+1; rs_ready for that reg rises at t+1.
//  All read ports independent; identical addresses on several ports return identical results.
//  dbg_data = mem[dbg_addr] registered-array value, ignores bypass and pending.
//  any_pending = |pending (registered state, 0-cycle combinational OR).
// TESTING
//  Reset low 3 cycles, release -> busy high exactly DEPTH(32) cycles after release; then all reads 0, ready=1.
//  Reset low again at clear index 10 -> clear restarts; busy high 32 further cycles after release.
//  READY: res_en addr 5; next cycle rs_addr0=5 -> rs_ready[0]=0, any_pending=1; wr_en 5=0xDEADBEEF
//   same cycle -> rs_data[0]=0xDEADBEEF, ready=1 (bypass); next cycle ready=1 from array, any_pending=0.
//  wr_en addr 0 data 0x1234 and res_en addr 0 -> rs_data for addr 0 stays 0, ready=1, any_pending=0.
//  Same-cycle wr_en+res_en addr 7 (0xA5A5A5A5) -> next cycle dbg_addr=7 gives 0xA5A5A5A5, rs_ready=0 on 7.
//  NUM_READ=3, BYPASS=0: write addr 9 at t -> all three ports on addr 9 show old value at t, new at t+1.

Source files
------------

// File: rtl/multiport_register_file.sv
// ---------------------------------------------------------------------------
// MultiportRegisterFile
// Integer register file sitting between decode and writeback. Provides
// NUM_READ combinational read ports and one write port, a write-to-read
// bypass, a per-register pending scoreboard (reserve at issue, release at
// writeback) and a clear engine that zeroes one entry per cycle after reset.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-low
//   rs_addr      read addresses, port i = [i*AW +: AW]
//   rs_data      read data, port i = [i*XLEN +: XLEN]
//   rs_ready     per-port valid (not pending, or bypass hit)
//   wr_en/wr_addr/wr_data   writeback port
//   res_en/res_addr         reserve (mark pending) port
//   dbg_addr/dbg_data       raw array tap, no bypass
//   busy         reset or clear in progress; strobes ignored
//   any_pending  OR of all pending bits
// ---------------------------------------------------------------------------
module multiport_register_file #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_READ*AW-1:0]   rs_addr,
    output logic [NUM_READ*XLEN-1:0] rs_data,
    output logic [NUM_READ-1:0]      rs_ready,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic                     res_en,
    input  logic [AW-1:0]            res_addr,
    input  logic [AW-1:0]            dbg_addr,
    output logic [XLEN-1:0]          dbg_data,
    output logic                     busy,
    output logic                     any_pending
);

    typedef enum logic {
        CLEARING = 1'b0,
        READY    = 1'b1
    } stateT;

    stateT               r_state;
    logic [AW-1:0]       r_clrIdx;
    logic [DEPTH-1:0]    r_pending;
    logic [XLEN-1:0]     r_mem [DEPTH];

    logic                w_wrLegal;
    logic                w_resLegal;

    // Busy is asserted combinationally while reset is held so that
    // consumers see a quiet register file from the very first reset cycle,
    // not only after the first clock edge has moved the state to CLEARING.
    assign busy = !reset || (r_state == CLEARING);

    // A write or reserve only counts when the file is idle and the target
    // is not the hardwired zero register.
    assign w_wrLegal  = wr_en  && !busy && !(ZERO_REG && (wr_addr  == '0));
    assign w_resLegal = res_en && !busy && !(ZERO_REG && (res_addr == '0));

    // Control state: clear sequencing and the pending scoreboard. The
    // reserve assignment follows the write-release so that a same-cycle
    // write and reserve to one register leaves it pending.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= CLEARING;
            r_clrIdx  <= '0;
            r_pending <= '0;
        end else if (r_state == CLEARING) begin
            r_clrIdx <= r_clrIdx + 1'b1;
            if (r_clrIdx == AW'(DEPTH - 1)) begin
                r_state <= READY;
            end
        end else begin
            if (w_wrLegal) begin
                r_pending[wr_addr] <= 1'b0;
            end
            if (w_resLegal) begin
                r_pending[res_addr] <= 1'b1;
            end
        end
    end

    // Storage array. It is not reset directly; the clear engine zeroes it
    // one entry per cycle once reset is released, which keeps the array
    // mappable onto plain RAM-style flops without a wide reset fan-out.
    always_ff @(posedge clock) begin
        if (reset && (r_state == CLEARING)) begin
            r_mem[r_clrIdx] <= '0;
        end else if (w_wrLegal) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read ports, all independent. Priority is zero register, then the
    // same-cycle bypass, then the stored value gated by the scoreboard.
    // A reserve issued this cycle only shows up next cycle because the
    // scoreboard is read from registered state.
    always_comb begin
        rs_data  = '0;
        rs_ready = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            logic [AW-1:0] w_addr;
            w_addr = rs_addr[i*AW +: AW];
            if (busy) begin
                rs_data[i*XLEN +: XLEN] = '0;
                rs_ready[i]             = 1'b0;
            end else if (ZERO_REG && (w_addr == '0)) begin
                rs_data[i*XLEN +: XLEN] = '0;
                rs_ready[i]             = 1'b1;
            end else if (BYPASS && w_wrLegal && (wr_addr == w_addr)) begin
                rs_data[i*XLEN +: XLEN] = wr_data;
                rs_ready[i]             = 1'b1;
            end else begin
                rs_data[i*XLEN +: XLEN] = r_mem[w_addr];
                rs_ready[i]             = !r_pending[w_addr];
            end
        end
    end

    // Debug tap and pending summary show registered state only, and are
    // silenced while the file is being reset or cleared.
    assign dbg_data    = busy ? '0 : r_mem[dbg_addr];
    assign any_pending = busy ? 1'b0 : |r_pending;

endmodule

// File: tb/tb_multiport_register_file.sv
// ---------------------------------------------------------------------------
// TbMultiportRegisterFile
// Directed bench for multiport_register_file. Instance dutA uses the default
// parameters (2 read ports, bypass on); instance dutB uses 3 read ports with
// bypass off. Both share clock and reset.
// ---------------------------------------------------------------------------
module tb_multiport_register_file;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clock;
    logic reset;

    // dutA signals
    logic [2*AW-1:0]   rsAddr;
    logic [2*XLEN-1:0] rsData;
    logic [1:0]        rsReady;
    logic              wrEn;
    logic [AW-1:0]     wrAddr;
    logic [XLEN-1:0]   wrData;
    logic              resEn;
    logic [AW-1:0]     resAddr;
    logic [AW-1:0]     dbgAddr;
    logic [XLEN-1:0]   dbgData;
    logic              busy;
    logic              anyPending;

    // dutB signals
    logic [3*AW-1:0]   bRsAddr;
    logic [3*XLEN-1:0] bRsData;
    logic [2:0]        bRsReady;
    logic              bWrEn;
    logic [AW-1:0]     bWrAddr;
    logic [XLEN-1:0]   bWrData;
    logic              bResEn;
    logic [AW-1:0]     bResAddr;
    logic [AW-1:0]     bDbgAddr;
    logic [XLEN-1:0]   bDbgData;
    logic              bBusy;
    logic              bAnyPending;

    int checkCount;
    int errorCount;
    int busyCycles;

    multiport_register_file #(
        .XLEN(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dutA (
        .clock(clock), .reset(reset),
        .rs_addr(rsAddr), .rs_data(rsData), .rs_ready(rsReady),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .res_en(resEn), .res_addr(resAddr),
        .dbg_addr(dbgAddr), .dbg_data(dbgData),
        .busy(busy), .any_pending(anyPending)
    );

    multiport_register_file #(
        .XLEN(32), .DEPTH(32), .NUM_READ(3), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dutB (
        .clock(clock), .reset(reset),
        .rs_addr(bRsAddr), .rs_data(bRsData), .rs_ready(bRsReady),
        .wr_en(bWrEn), .wr_addr(bWrAddr), .wr_data(bWrData),
        .res_en(bResEn), .res_addr(bResAddr),
        .dbg_addr(bDbgAddr), .dbg_data(bDbgData),
        .busy(bBusy), .any_pending(bAnyPending)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive all dutA strobes and addresses in one go.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                                 input logic [XLEN-1:0] wd, input logic re,
                                 input logic [AW-1:0] ra);
        wrEn    = we;
        wrAddr  = wa;
        wrData  = wd;
        resEn   = re;
        resAddr = ra;
    endtask

    // Counts negedge samples with busy high, starting right after release.
    // When poke is set, strobes to register 2 are driven mid-clear; they
    // must be ignored.
    task automatic countBusy(input bit poke, output int n);
        n = 0;
        #1;
        while (busy && n < 200) begin
            n++;
            if (poke && n == 5) applyStimulus(1'b1, 5'd2, 32'hCAFE, 1'b1, 5'd2);
            else if (poke && n == 6) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            @(negedge clock);
            #1;
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset    = 1'b0;
        rsAddr   = '0;
        dbgAddr  = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        bRsAddr  = '0;
        bWrEn    = 1'b0;
        bWrAddr  = '0;
        bWrData  = '0;
        bResEn   = 1'b0;
        bResAddr = '0;
        bDbgAddr = '0;

        // Reset held three cycles
        repeat (3) @(negedge clock);
        #1;
        checkOutput("busy_in_reset", 64'(busy), 64'd1);
        checkOutput("ready_in_reset", 64'(rsReady), 64'd0);

        reset = 1'b1;
        countBusy(1'b0, busyCycles);
        checkOutput("busy_len_first", 64'(busyCycles), 64'd32);
        checkOutput("b_busy_done", 64'(bBusy), 64'd0);

        // After clear: everything reads zero and ready
        rsAddr = {5'd31, 5'd3};
        dbgAddr = 5'd17;
        #1;
        checkOutput("clr_data", 64'(rsData), 64'd0);
        checkOutput("clr_ready", 64'(rsReady), 64'd3);
        checkOutput("clr_pending", 64'(anyPending), 64'd0);
        checkOutput("clr_dbg", 64'(dbgData), 64'd0);

        // Reserve 5: no same-cycle effect, pending next cycle
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        rsAddr = {5'd0, 5'd5};
        #1;
        checkOutput("res_same_cycle_ready", 64'(rsReady[0]), 64'd1);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("res_next_ready", 64'(rsReady[0]), 64'd0);
        checkOutput("res_any_pending", 64'(anyPending), 64'd1);

        // Writeback of 5 with bypass; debug still shows old array value
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        dbgAddr = 5'd5;
        #1;
        checkOutput("bypass_data", 64'(rsData[31:0]), 64'hDEADBEEF);
        checkOutput("bypass_ready", 64'(rsReady[0]), 64'd1);
        checkOutput("dbg_no_bypass", 64'(dbgData), 64'd0);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("array_data", 64'(rsData[31:0]), 64'hDEADBEEF);
        checkOutput("array_ready", 64'(rsReady[0]), 64'd1);
        checkOutput("release_pending", 64'(anyPending), 64'd0);
        checkOutput("dbg_after_wr", 64'(dbgData), 64'hDEADBEEF);

        // Register 0 ignores writes and reserves
        @(negedge clock);
        applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
        rsAddr = {5'd0, 5'd5};
        #1;
        checkOutput("zero_bypass_data", 64'(rsData[63:32]), 64'd0);
        checkOutput("zero_bypass_ready", 64'(rsReady[1]), 64'd1);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        dbgAddr = 5'd0;
        #1;
        checkOutput("zero_data", 64'(rsData[63:32]), 64'd0);
        checkOutput("zero_ready", 64'(rsReady[1]), 64'd1);
        checkOutput("zero_pending", 64'(anyPending), 64'd0);
        checkOutput("zero_dbg", 64'(dbgData), 64'd0);

        // Same-cycle write and reserve on 7: data lands, pending wins
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7);
        rsAddr = {5'd7, 5'd7};
        #1;
        checkOutput("wr_res_bypass", 64'(rsData[31:0]), 64'hA5A5A5A5);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        dbgAddr = 5'd7;
        #1;
        checkOutput("wr_res_dbg", 64'(dbgData), 64'hA5A5A5A5);
        checkOutput("wr_res_ready", 64'(rsReady), 64'd0);
        checkOutput("wr_res_ports_equal", 64'(rsData[63:32]), 64'hA5A5A5A5);
        checkOutput("wr_res_pending", 64'(anyPending), 64'd1);

        // Release 7, then seed register 20 and reserve 12
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd12);
        @(negedge clock);
        applyStimulus(1'b1, 5'd20, 32'h11112222, 1'b0, 5'd0);
        @(negedge clock);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        dbgAddr = 5'd20;
        rsAddr = {5'd12, 5'd7};
        #1;
        checkOutput("seed_dbg", 64'(dbgData), 64'h11112222);
        checkOutput("seed_ready", 64'(rsReady), 64'b01);
        checkOutput("seed_pending", 64'(anyPending), 64'd1);

        // dutB without bypass: old value same cycle, new value next cycle
        @(negedge clock);
        bWrEn = 1'b1; bWrAddr = 5'd9; bWrData = 32'h0BADF00D;
        @(negedge clock);
        bWrData = 32'h12345678;
        bRsAddr = {5'd9, 5'd9, 5'd9};
        #1;
        checkOutput("nobyp_old", 64'(bRsData[95:64] ^ bRsData[63:32] ^ bRsData[31:0]),
                    64'h0BADF00D);
        checkOutput("nobyp_old_p1", 64'(bRsData[63:32]), 64'h0BADF00D);
        checkOutput("nobyp_ready", 64'(bRsReady), 64'd7);
        @(negedge clock);
        bWrEn = 1'b0;
        #1;
        checkOutput("nobyp_new_p0", 64'(bRsData[31:0]), 64'h12345678);
        checkOutput("nobyp_new_p2", 64'(bRsData[95:64]), 64'h12345678);

        // Reset again, interrupt the clear at index 10, then let it finish
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("busy_mid_reset", 64'(busy), 64'd1);
        checkOutput("pending_mid_reset", 64'(anyPending), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        countBusy(1'b1, busyCycles);
        checkOutput("busy_len_restart", 64'(busyCycles), 64'd32);
        dbgAddr = 5'd20;
        rsAddr = {5'd2, 5'd12};
        #1;
        checkOutput("restart_dbg20", 64'(dbgData), 64'd0);
        checkOutput("restart_pending", 64'(anyPending), 64'd0);
        checkOutput("restart_ready", 64'(rsReady), 64'd3);
        checkOutput("busy_write_ignored", 64'(rsData[63:32]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
